frame_average_pipe: RTL
=======================

// Module: frame_average_pipe
// PURPOSE
//  Multi-lane, pipelined adaptive temporal (frame-to-frame) filter for the BlowOut video path.
//  Blends each incoming pixel toward its stored previous-frame pixel.
//  The blend weight is set per pixel by |new-old|, with runtime thresholds and gains.
//  Sits between frame-buffer readback (old_pix) and the output formatter; valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_WIDTH  16  pixel width, bits
//  PRECISION   8   fractional bits of the blend coefficient k (k = value / 2^PRECISION)
//  LANES       2   pixels per beat, processed in parallel; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  CNT_WIDTH   24  width of the frame motion counter
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-high
//  en             in   1                 1 = filter, 0 = pass new_pix through (still pipelined)
//  cfg_bord_low   in   DATA_WIDTH        lower delta threshold
//  cfg_bord_high  in   DATA_WIDTH        upper delta threshold (> cfg_bord_low)
//  cfg_k_low      in   PRECISION         k used below cfg_bord_low
//  cfg_k_high     in   PRECISION         k used above cfg_bord_high
//  cfg_slope      in   PRECISION+8       (k_high-k_low)/(high-low), unsigned Q8.PRECISION, computed by SW
//  in_valid       in   1                 input beat valid
//  in_ready       out  1                 input beat accepted when in_valid & in_ready
//  in_sof, in_eof in   1                 first / last beat of frame
//  new_pix        in   LANES*DATA_WIDTH  current-frame pixels
//  old_pix        in   LANES*DATA_WIDTH  previous-frame pixels (same positions)
//  out_valid      out  1                 output beat valid
//  out_ready      in   1                 downstream accept
//  out_pix        out  LANES*DATA_WIDTH  filtered pixels
//  out_sof, out_eof out 1                sof/eof, delayed in step with out_pix
//  primed         out  1                 1 while state == FILTER
// BEHAVIOUR
//  Reset: out_valid=0, out_pix=0, out_sof=0, out_eof=0, primed=0, pipe valids=0, state=IDLE, cfg shadow=0.
//  Reset mid-frame discards all in-flight beats; nothing is emitted for them.
//  Pipeline: 3 stages. S1: |delta|, direction. S2: k. S3: blended pixel. Latency 3 cycles with no stall.
//  Handshake: ce = out_ready | ~out_valid; in_ready = ce; all stages advance only when ce.
//  Stall holds every stage. out_pix and out_valid stay stable while out_valid & ~out_ready.
//  cfg_* captured into a shadow register on an accepted in_sof beat; mid-frame cfg changes are ignored.
//  FSM (advances on accepted beats):
//   IDLE   -> PRIME on sof.
//   PRIME  -> FILTER on eof.
//   FILTER stays FILTER.
//   Any state -> IDLE on reset.
//   In IDLE and PRIME, out_pix = new_pix: no valid history exists yet.
//   Beats accepted in IDLE without sof pass through and do not change state.
//   en=0 forces pass-through; the FSM still tracks frames.
//   sof while in PRIME restarts the prime frame.
//  k per lane:
//   delta < low          -> k_low
//   delta > high         -> k_high
//   otherwise            -> k_low + (((delta-low)*cfg_slope) >> PRECISION), saturated to k_high
//  Blend: new>old ? old + ((k*delta)>>PRECISION) : old - ((k*delta)>>PRECISION).
//   Truncation is toward old.
//   Result always lies in [min(old,new), max(old,new)]; no overflow or wrap.
//  Intermediate products are full width: DATA_WIDTH+PRECISION+8 for the slope term, DATA_WIDTH+PRECISION for the blend.
// CONFIGURATION
//  FRAME_AVERAGE_STATS_EN defined:
//   adds outputs motion_cnt [CNT_WIDTH] and motion_valid [1].
//   Counts lanes with delta > bord_high per frame; counting is active in FILTER only.
//   motion_cnt latches on the output eof beat; motion_valid pulses 1 cycle.
//   Internal counter clears on sof and saturates at all-ones.
//  Not defined: ports and logic are absent; filtering behaviour is identical.
// STRUCTURE
//  Package frame_average_pkg:
//   cfg struct (bord_low, bord_high, k_low, k_high, slope)
//   FSM state encoding (IDLE, PRIME, FILTER)
//   width localparams: PROD_W, SLOPE_W
//  Sub-module frame_average_lane: one lane's 3-stage datapath with ce input, instantiated LANES times.
//  Top level holds the handshake, FSM, cfg shadow and stats.
// TESTING (DW=16, P=8, low=20, high=50, k_low=2, k_high=191, slope=1612)
//  1. After reset, frame 1: new=135, old=100 -> out=135 (PRIME pass-through); primed=1 after eof.
//  2. FILTER, delta in ramp: old=100, new=135 -> k=96 -> out=113, 3 cycles after accept.
//  3. Thresholds: old=100,new=110 -> 100; old=100,new=160 -> 144; old=160,new=100 -> 116.
//  4. Backpressure: out_ready=0 for 5 cycles mid-frame -> in_ready=0, out_pix held; no beat lost or duplicated.
//  5. cfg_k_high changed mid-frame -> old value used until next sof; en=0 -> out=new_pix; reset mid-frame -> out_valid=0 next cycle, state IDLE.
//  6. STATS_EN: frame with 7 lane-beats delta>50 -> motion_cnt=7 with motion_valid on output eof.

Source files
------------

// File: rtl/frame_average_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_average_pkg
// Brief    : Shared types and widths for the frame_average_pipe temporal
//            filter: configuration shadow struct, FSM encoding and the
//            full-width intermediate product sizes.
// Revision : 1.0 - initial release
// ============================================================================
package frame_average_pkg;

    // Reference pixel width and blend-coefficient precision; the configuration
    // struct below is sized from these, so the top-level parameters must match.
    localparam int c_data_width = 16;
    localparam int c_precision  = 8;

    // Blend product: k (PRECISION bits) times |delta| (DATA_WIDTH bits).
    localparam int PROD_W  = c_data_width + c_precision;
    // Slope product: (delta-low) (DATA_WIDTH bits) times Q8.PRECISION slope.
    localparam int SLOPE_W = c_data_width + c_precision + 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_FILTER = 2'd2
    } fa_state_t;

    typedef struct packed {
        logic [c_data_width-1:0] bord_low;
        logic [c_data_width-1:0] bord_high;
        logic [c_precision-1:0]  k_low;
        logic [c_precision-1:0]  k_high;
        logic [c_precision+7:0]  slope;
    } fa_cfg_t;

endpackage : frame_average_pkg
`default_nettype wire

// File: rtl/frame_average_lane.sv
`default_nettype none
// ============================================================================
// Module   : frame_average_lane
// Brief    : One pixel lane of the adaptive temporal filter. Three stages:
//            S1 |delta| and direction, S2 blend coefficient k, S3 blended
//            pixel. All stages advance together on i_ce.
//            FRAME_AVERAGE_STATS_EN adds a per-beat "delta > bord_high" flag
//            aligned with o_pix.
// Revision : 1.0 - initial release
// ============================================================================
module frame_average_lane
    import frame_average_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int PRECISION  = c_precision
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ce,
    input  logic                  i_pass,
    input  logic [DATA_WIDTH-1:0] i_new,
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_bord_low,
    input  logic [DATA_WIDTH-1:0] i_bord_high,
    input  logic [PRECISION-1:0]  i_k_low,
    input  logic [PRECISION-1:0]  i_k_high,
    input  logic [PRECISION+7:0]  i_slope,
`ifdef FRAME_AVERAGE_STATS_EN
    output logic                  o_motion,
`endif
    output logic [DATA_WIDTH-1:0] o_pix
);

    // ---------------- S1: absolute difference and direction ----------------
    logic                  w_dir;
    logic [DATA_WIDTH-1:0] w_delta;
    logic                  r1_dir;
    logic                  r1_pass;
    logic [DATA_WIDTH-1:0] r1_delta;
    logic [DATA_WIDTH-1:0] r1_old;
    logic [DATA_WIDTH-1:0] r1_new;

    assign w_dir   = (i_new > i_old);
    assign w_delta = w_dir ? (i_new - i_old) : (i_old - i_new);

    // S1 register: capture delta, direction and the raw pixels
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_dir   <= 1'b0;
            r1_pass  <= 1'b0;
            r1_delta <= '0;
            r1_old   <= '0;
            r1_new   <= '0;
        end else if (i_ce) begin
            r1_dir   <= w_dir;
            r1_pass  <= i_pass;
            r1_delta <= w_delta;
            r1_old   <= i_old;
            r1_new   <= i_new;
        end
    end

    // ---------------- S2: blend coefficient ----------------
    logic                  w_below;
    logic                  w_above;
    logic [DATA_WIDTH-1:0] w_ramp_diff;
    logic [SLOPE_W-1:0]    w_slope_prod;
    logic [SLOPE_W-1:0]    w_ramp;
    logic [PRECISION-1:0]  w_k;

    assign w_below      = (r1_delta < i_bord_low);
    assign w_above      = (r1_delta > i_bord_high);
    // Only meaningful when delta >= bord_low; the wrapped value is unused otherwise.
    assign w_ramp_diff  = r1_delta - i_bord_low;
    assign w_slope_prod = SLOPE_W'(w_ramp_diff) * SLOPE_W'(i_slope);
    assign w_ramp       = SLOPE_W'(i_k_low) + (w_slope_prod >> PRECISION);

    // Select k: flat below/above the thresholds, linear ramp in between (capped at k_high)
    always_comb begin
        w_k = i_k_low;
        if (w_below) begin
            w_k = i_k_low;
        end else if (w_above) begin
            w_k = i_k_high;
        end else if (w_ramp > SLOPE_W'(i_k_high)) begin
            w_k = i_k_high;
        end else begin
            w_k = PRECISION'(w_ramp);
        end
    end

    logic                  r2_dir;
    logic                  r2_pass;
    logic [PRECISION-1:0]  r2_k;
    logic [DATA_WIDTH-1:0] r2_delta;
    logic [DATA_WIDTH-1:0] r2_old;
    logic [DATA_WIDTH-1:0] r2_new;

    // S2 register: coefficient plus the operands the blend still needs
    always_ff @(posedge clk) begin
        if (reset) begin
            r2_dir   <= 1'b0;
            r2_pass  <= 1'b0;
            r2_k     <= '0;
            r2_delta <= '0;
            r2_old   <= '0;
            r2_new   <= '0;
        end else if (i_ce) begin
            r2_dir   <= r1_dir;
            r2_pass  <= r1_pass;
            r2_k     <= w_k;
            r2_delta <= r1_delta;
            r2_old   <= r1_old;
            r2_new   <= r1_new;
        end
    end

    // ---------------- S3: blended pixel ----------------
    logic [PROD_W-1:0]     w_blend_prod;
    logic [DATA_WIDTH-1:0] w_step;
    logic [DATA_WIDTH-1:0] w_result;

    // k < 1.0 so the step never exceeds delta: the result stays between old and new.
    assign w_blend_prod = PROD_W'(r2_k) * PROD_W'(r2_delta);
    assign w_step       = DATA_WIDTH'(w_blend_prod >> PRECISION);

    // Move old toward new by the truncated step, or pass new through unchanged
    always_comb begin
        w_result = r2_new;
        if (!r2_pass) begin
            w_result = r2_dir ? (r2_old + w_step) : (r2_old - w_step);
        end
    end

    // S3 register: lane output pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            o_pix <= '0;
        end else if (i_ce) begin
            o_pix <= w_result;
        end
    end

`ifdef FRAME_AVERAGE_STATS_EN
    logic r2_motion;

    // Motion flag follows the beat through S2/S3 so it lines up with o_pix
    always_ff @(posedge clk) begin
        if (reset) begin
            r2_motion <= 1'b0;
            o_motion  <= 1'b0;
        end else if (i_ce) begin
            r2_motion <= w_above;
            o_motion  <= r2_motion;
        end
    end
`endif

endmodule : frame_average_lane
`default_nettype wire

// File: rtl/frame_average_pipe.sv
`default_nettype none
// ============================================================================
// Module   : frame_average_pipe
// Brief    : Multi-lane pipelined adaptive temporal filter. Holds the
//            valid/ready handshake, frame FSM (IDLE/PRIME/FILTER), the
//            per-frame configuration shadow and optional motion statistics.
//            Optional feature macro: FRAME_AVERAGE_STATS_EN (adds motion_cnt
//            and motion_valid outputs).
// Revision : 1.0 - initial release
// ============================================================================
module frame_average_pipe
    import frame_average_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int PRECISION  = c_precision,
    parameter int LANES      = 2,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [DATA_WIDTH-1:0]       cfg_bord_low,
    input  logic [DATA_WIDTH-1:0]       cfg_bord_high,
    input  logic [PRECISION-1:0]        cfg_k_low,
    input  logic [PRECISION-1:0]        cfg_k_high,
    input  logic [PRECISION+7:0]        cfg_slope,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sof,
    input  logic                        in_eof,
    input  logic [LANES*DATA_WIDTH-1:0] new_pix,
    input  logic [LANES*DATA_WIDTH-1:0] old_pix,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_pix,
    output logic                        out_sof,
    output logic                        out_eof,
`ifdef FRAME_AVERAGE_STATS_EN
    output logic [CNT_WIDTH-1:0]        motion_cnt,
    output logic                        motion_valid,
`endif
    output logic                        primed
);

    // ---------------- handshake ----------------
    logic w_ce;
    logic w_accept;

    // The whole pipe moves as one: it advances whenever the output slot is free.
    assign w_ce     = out_ready | ~out_valid;
    assign in_ready = w_ce;
    assign w_accept = in_valid & w_ce;

    // ---------------- configuration shadow ----------------
    fa_cfg_t w_cfg_in;
    fa_cfg_t r_cfg;

    always_comb begin
        w_cfg_in           = '0;
        w_cfg_in.bord_low  = cfg_bord_low;
        w_cfg_in.bord_high = cfg_bord_high;
        w_cfg_in.k_low     = cfg_k_low;
        w_cfg_in.k_high    = cfg_k_high;
        w_cfg_in.slope     = cfg_slope;
    end

    // Latch cfg on each accepted start-of-frame; S2 reads it one stage later,
    // which is exactly when the sof beat itself reaches S2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (w_accept && in_sof) begin
            r_cfg <= w_cfg_in;
        end
    end

    // ---------------- frame FSM ----------------
    fa_state_t r_state;
    fa_state_t w_state_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: only accepted beats move the FSM
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_sof) w_state_next = ST_PRIME;
                end
                ST_PRIME: begin
                    // sof alone restarts priming (stay); eof completes it
                    if (in_eof) w_state_next = ST_FILTER;
                end
                ST_FILTER: begin
                    w_state_next = ST_FILTER;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign primed = (r_state == ST_FILTER);

    // Without a completed previous frame there is no history to blend with.
    logic w_pass;
    assign w_pass = ~en | (r_state != ST_FILTER);

    // ---------------- control pipeline ----------------
    logic r_v1, r_v2;
    logic r_sof1, r_sof2;
    logic r_eof1, r_eof2;

    // Valid/sof/eof travel alongside the lane datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
            r_sof1    <= 1'b0;
            r_sof2    <= 1'b0;
            out_sof   <= 1'b0;
            r_eof1    <= 1'b0;
            r_eof2    <= 1'b0;
            out_eof   <= 1'b0;
        end else if (w_ce) begin
            r_v1      <= in_valid;
            r_v2      <= r_v1;
            out_valid <= r_v2;
            r_sof1    <= in_sof;
            r_sof2    <= r_sof1;
            out_sof   <= r_sof2;
            r_eof1    <= in_eof;
            r_eof2    <= r_eof1;
            out_eof   <= r_eof2;
        end
    end

    // ---------------- lanes ----------------
`ifdef FRAME_AVERAGE_STATS_EN
    logic [LANES-1:0] w_motion;
`endif

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            frame_average_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .PRECISION  (PRECISION)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .i_ce        (w_ce),
                .i_pass      (w_pass),
                .i_new       (new_pix[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_old       (old_pix[g*DATA_WIDTH +: DATA_WIDTH]),
                .i_bord_low  (r_cfg.bord_low),
                .i_bord_high (r_cfg.bord_high),
                .i_k_low     (r_cfg.k_low),
                .i_k_high    (r_cfg.k_high),
                .i_slope     (r_cfg.slope),
`ifdef FRAME_AVERAGE_STATS_EN
                .o_motion    (w_motion[g]),
`endif
                .o_pix       (out_pix[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

`ifdef FRAME_AVERAGE_STATS_EN
    // ---------------- motion statistics ----------------
    logic                 r_filt1, r_filt2, r_filt3;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH:0]   w_pop;
    logic [CNT_WIDTH:0]   w_sum;
    logic [CNT_WIDTH-1:0] w_sum_sat;

    // Tag each beat with whether it was accepted in FILTER
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt1 <= 1'b0;
            r_filt2 <= 1'b0;
            r_filt3 <= 1'b0;
        end else if (w_ce) begin
            r_filt1 <= (r_state == ST_FILTER);
            r_filt2 <= r_filt1;
            r_filt3 <= r_filt2;
        end
    end

    // Running total including the beat at the output; sof restarts it
    always_comb begin
        w_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pop = w_pop + {{CNT_WIDTH{1'b0}}, (w_motion[l] & r_filt3)};
        end
        w_sum     = (out_sof ? '0 : {1'b0, r_cnt}) + w_pop;
        w_sum_sat = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
    end

    // Accumulate on output transfers; publish the total on the eof beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            motion_cnt   <= '0;
            motion_valid <= 1'b0;
        end else begin
            motion_valid <= 1'b0;
            if (out_valid && out_ready) begin
                r_cnt <= w_sum_sat;
                if (out_eof) begin
                    motion_cnt   <= w_sum_sat;
                    motion_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule : frame_average_pipe
`default_nettype wire
